// File: rtl/control_decode_stage.sv
// control_decode_stage: registered RV32I decode stage with a 2-entry skid buffer.
// Decodes the class, ALU code, memory size and immediate of the instruction offered by
// fetch, then stores the result in a main/skid register pair. flush empties the stage.
// The counter of accepted illegal instructions saturates and survives flush.
// Optional feature: define M_EXT_EN to decode the RV32M multiply/divide group
// (opcode 0x33, funct7 0x01) as r_type with ALU codes 16..23.
module control_decode_stage #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [31:0]      out_imm,
  output logic             out_store,
  output logic             out_load,
  output logic             out_i_type,
  output logic             out_r_type,
  output logic             out_branch,
  output logic             out_upper,
  output logic             out_add_u_pc,
  output logic             out_jmp_link,
  output logic             out_jmp_linkr,
  output logic [1:0]       out_mem_size,
  output logic             out_mem_unsigned,
  output logic [4:0]       out_alu_ctrl,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [6:0] OpLoad   = 7'h03;
  localparam logic [6:0] OpStore  = 7'h23;
  localparam logic [6:0] OpImm    = 7'h13;
  localparam logic [6:0] OpReg    = 7'h33;
  localparam logic [6:0] OpBranch = 7'h63;
  localparam logic [6:0] OpLui    = 7'h37;
  localparam logic [6:0] OpAuipc  = 7'h17;
  localparam logic [6:0] OpJal    = 7'h6F;
  localparam logic [6:0] OpJalr   = 7'h67;

  localparam logic [4:0] AluAdd   = 5'd0;
  localparam logic [4:0] AluSub   = 5'd1;
  localparam logic [4:0] AluSll   = 5'd2;
  localparam logic [4:0] AluSlt   = 5'd3;
  localparam logic [4:0] AluSltu  = 5'd4;
  localparam logic [4:0] AluXor   = 5'd5;
  localparam logic [4:0] AluSrl   = 5'd6;
  localparam logic [4:0] AluSra   = 5'd7;
  localparam logic [4:0] AluOr    = 5'd8;
  localparam logic [4:0] AluAnd   = 5'd9;
  localparam logic [4:0] AluPassB = 5'd10;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [31:0]     imm;
    logic            store;
    logic            load;
    logic            i_type;
    logic            r_type;
    logic            branch;
    logic            upper;
    logic            add_u_pc;
    logic            jmp_link;
    logic            jmp_linkr;
    logic [1:0]      mem_size;
    logic            mem_unsigned;
    logic [4:0]      alu_ctrl;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  // Plain register-register / register-immediate operation selected by funct3
  function automatic logic [4:0] alu_of_funct3(input logic [2:0] f3);
    logic [4:0] a;
    case (f3)
      3'd0:    a = AluAdd;
      3'd1:    a = AluSll;
      3'd2:    a = AluSlt;
      3'd3:    a = AluSltu;
      3'd4:    a = AluXor;
      3'd5:    a = AluSrl;
      3'd6:    a = AluOr;
      default: a = AluAnd;
    endcase
    return a;
  endfunction

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;
  logic        w_bad;
  entry_t      w_dec;

  assign w_opcode = in_instr[6:0];
  assign w_funct3 = in_instr[14:12];
  assign w_funct7 = in_instr[31:25];
  assign w_imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign w_imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
  assign w_imm_u  = {in_instr[31:12], 12'b0};
  assign w_imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};
  // Shift-immediates carry only the shamt, funct7 selects SRL/SRA
  assign w_imm_sh = {27'b0, in_instr[24:20]};

  // Combinational decode of the offered instruction
  always_comb begin
    w_bad        = 1'b0;
    w_dec        = '0;
    w_dec.pc     = in_pc;
    w_dec.rd     = in_instr[11:7];
    w_dec.rs1    = in_instr[19:15];
    w_dec.rs2    = in_instr[24:20];
    case (w_opcode)
      OpLoad: begin
        w_dec.load         = 1'b1;
        w_dec.imm          = w_imm_i;
        w_dec.mem_size     = w_funct3[1:0];
        w_dec.mem_unsigned = w_funct3[2];
        w_bad              = (w_funct3 == 3'd3) || (w_funct3 >= 3'd6);
      end
      OpStore: begin
        w_dec.store    = 1'b1;
        w_dec.imm      = w_imm_s;
        w_dec.mem_size = w_funct3[1:0];
        w_bad          = (w_funct3 > 3'd2);
      end
      OpImm: begin
        w_dec.i_type   = 1'b1;
        w_dec.imm      = w_imm_i;
        w_dec.alu_ctrl = alu_of_funct3(w_funct3);
        if (w_funct3 == 3'd1) begin
          w_dec.imm = w_imm_sh;
          w_bad     = (w_funct7 != 7'h00);
        end else if (w_funct3 == 3'd5) begin
          w_dec.imm = w_imm_sh;
          if (w_funct7 == 7'h20) w_dec.alu_ctrl = AluSra;
          else if (w_funct7 != 7'h00) w_bad = 1'b1;
        end
      end
      OpReg: begin
        w_dec.r_type = 1'b1;
        if (w_funct7 == 7'h00) begin
          w_dec.alu_ctrl = alu_of_funct3(w_funct3);
        end else if (w_funct7 == 7'h20 && w_funct3 == 3'd0) begin
          w_dec.alu_ctrl = AluSub;
        end else if (w_funct7 == 7'h20 && w_funct3 == 3'd5) begin
          w_dec.alu_ctrl = AluSra;
`ifdef M_EXT_EN
        end else if (w_funct7 == 7'h01) begin
          w_dec.alu_ctrl = {2'b10, w_funct3};
`endif
        end else begin
          w_bad = 1'b1;
        end
      end
      OpBranch: begin
        w_dec.branch = 1'b1;
        w_dec.imm    = w_imm_b;
        w_bad        = (w_funct3 == 3'd2) || (w_funct3 == 3'd3);
      end
      OpLui: begin
        w_dec.upper    = 1'b1;
        w_dec.imm      = w_imm_u;
        w_dec.alu_ctrl = AluPassB;
      end
      OpAuipc: begin
        w_dec.add_u_pc = 1'b1;
        w_dec.imm      = w_imm_u;
      end
      OpJal: begin
        w_dec.jmp_link = 1'b1;
        w_dec.imm      = w_imm_j;
      end
      OpJalr: begin
        w_dec.jmp_linkr = 1'b1;
        w_dec.imm       = w_imm_i;
        w_bad           = (w_funct3 != 3'd0);
      end
      default: w_bad = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11) w_bad = 1'b1;
    // Illegal entries keep pc and register fields but carry no control
    if (w_bad) begin
      w_dec.imm          = '0;
      w_dec.store        = 1'b0;
      w_dec.load         = 1'b0;
      w_dec.i_type       = 1'b0;
      w_dec.r_type       = 1'b0;
      w_dec.branch       = 1'b0;
      w_dec.upper        = 1'b0;
      w_dec.add_u_pc     = 1'b0;
      w_dec.jmp_link     = 1'b0;
      w_dec.jmp_linkr    = 1'b0;
      w_dec.mem_size     = 2'd0;
      w_dec.mem_unsigned = 1'b0;
      w_dec.alu_ctrl     = AluAdd;
      w_dec.illegal      = 1'b1;
    end
  end

  state_e           r_state, w_state_next;
  entry_t           r_main, w_main_next;
  entry_t           r_skid, w_skid_next;
  logic             r_in_ready, w_in_ready_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             w_accept, w_pop;

  assign w_accept = in_valid & r_in_ready;
  assign w_pop    = out_valid & out_ready;

  // Next-state for occupancy, storage, counter and the registered in_ready
  always_comb begin
    w_state_next = r_state;
    w_main_next  = r_main;
    w_skid_next  = r_skid;
    w_cnt_next   = r_cnt;
    if (flush) begin
      w_state_next = StEmpty;
    end else begin
      case (r_state)
        StEmpty: begin
          if (w_accept) begin
            w_main_next  = w_dec;
            w_state_next = StOne;
          end
        end
        StOne: begin
          if (w_accept && w_pop) begin
            w_main_next = w_dec;
          end else if (w_accept) begin
            w_skid_next  = w_dec;
            w_state_next = StFull;
          end else if (w_pop) begin
            w_state_next = StEmpty;
          end
        end
        StFull: begin
          if (w_pop) begin
            w_main_next  = r_skid;
            w_state_next = StOne;
          end
        end
        default: w_state_next = StEmpty;
      endcase
      if (w_accept && w_dec.illegal && (r_cnt != {CNT_W{1'b1}})) begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
    w_in_ready_next = (w_state_next != StFull);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= StEmpty;
      r_main     <= '0;
      r_skid     <= '0;
      r_in_ready <= 1'b1;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_main     <= w_main_next;
      r_skid     <= w_skid_next;
      r_in_ready <= w_in_ready_next;
      r_cnt      <= w_cnt_next;
    end
  end

  assign in_ready         = r_in_ready;
  assign out_valid        = (r_state != StEmpty);
  assign out_pc           = r_main.pc;
  assign out_rd           = r_main.rd;
  assign out_rs1          = r_main.rs1;
  assign out_rs2          = r_main.rs2;
  assign out_imm          = r_main.imm;
  assign out_store        = r_main.store;
  assign out_load         = r_main.load;
  assign out_i_type       = r_main.i_type;
  assign out_r_type       = r_main.r_type;
  assign out_branch       = r_main.branch;
  assign out_upper        = r_main.upper;
  assign out_add_u_pc     = r_main.add_u_pc;
  assign out_jmp_link     = r_main.jmp_link;
  assign out_jmp_linkr    = r_main.jmp_linkr;
  assign out_mem_size     = r_main.mem_size;
  assign out_mem_unsigned = r_main.mem_unsigned;
  assign out_alu_ctrl     = r_main.alu_ctrl;
  assign out_illegal      = r_main.illegal;
  assign illegal_count    = r_cnt;

endmodule

// File: tb/tb_control_decode_stage.sv
// Scoreboard bench for control_decode_stage: directed cases then randomized traffic
// with back-pressure, flush and reset, checked against a behavioural decode model.
// A second instance with a 3-bit counter exercises saturation.
module tb_control_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        st, ld, it, rt, br, up, ap, jl, jr;
    logic [1:0]  msz;
    logic        muns;
    logic [4:0]  alu;
    logic        ill;
  } exp_t;

`ifdef M_EXT_EN
  localparam bit MExt = 1'b1;
`else
  localparam bit MExt = 1'b0;
`endif
  // ALU code for funct3 0..7 of plain OP/OP-IMM
  localparam int F3Alu [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  out_rd, out_rs1, out_rs2, out_alu_ctrl;
  logic        out_store, out_load, out_i_type, out_r_type, out_branch, out_upper;
  logic        out_add_u_pc, out_jmp_link, out_jmp_linkr, out_mem_unsigned, out_illegal;
  logic [1:0]  out_mem_size;
  logic [15:0] illegal_count;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_pc, s_out_imm;
  logic [4:0]  s_out_rd, s_out_rs1, s_out_rs2, s_out_alu_ctrl;
  logic        s_out_store, s_out_load, s_out_i_type, s_out_r_type, s_out_branch, s_out_upper;
  logic        s_out_add_u_pc, s_out_jmp_link, s_out_jmp_linkr, s_out_mem_unsigned;
  logic        s_out_illegal;
  logic [1:0]  s_out_mem_size;
  logic [2:0]  s_illegal_count;

  always #5 clk = ~clk;

  control_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_imm(out_imm), .out_store(out_store), .out_load(out_load),
    .out_i_type(out_i_type), .out_r_type(out_r_type), .out_branch(out_branch),
    .out_upper(out_upper), .out_add_u_pc(out_add_u_pc), .out_jmp_link(out_jmp_link),
    .out_jmp_linkr(out_jmp_linkr), .out_mem_size(out_mem_size),
    .out_mem_unsigned(out_mem_unsigned), .out_alu_ctrl(out_alu_ctrl),
    .out_illegal(out_illegal), .illegal_count(illegal_count)
  );

  control_decode_stage #(.PC_W(32), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_pc(s_out_pc), .out_rd(s_out_rd), .out_rs1(s_out_rs1),
    .out_rs2(s_out_rs2), .out_imm(s_out_imm), .out_store(s_out_store),
    .out_load(s_out_load), .out_i_type(s_out_i_type), .out_r_type(s_out_r_type),
    .out_branch(s_out_branch), .out_upper(s_out_upper), .out_add_u_pc(s_out_add_u_pc),
    .out_jmp_link(s_out_jmp_link), .out_jmp_linkr(s_out_jmp_linkr),
    .out_mem_size(s_out_mem_size), .out_mem_unsigned(s_out_mem_unsigned),
    .out_alu_ctrl(s_out_alu_ctrl), .out_illegal(s_out_illegal),
    .illegal_count(s_illegal_count)
  );

  exp_t        q[$];
  int          n_checks = 0;
  int          n_err = 0;
  int          cnt = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  // Reference decode from the RV32I rules
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t       e;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic       ok;
    e     = '0;
    op    = ins[6:0];
    f3    = ins[14:12];
    f7    = ins[31:25];
    ok    = 1'b1;
    e.pc  = pc;
    e.rd  = ins[11:7];
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    if (op == 7'h33) begin
      e.rt = 1'b1;
      if (f7 == 7'h00) e.alu = 5'(F3Alu[f3]);
      else if (f7 == 7'h20 && f3 == 3'd0) e.alu = 5'd1;
      else if (f7 == 7'h20 && f3 == 3'd5) e.alu = 5'd7;
      else if (MExt && f7 == 7'h01) e.alu = 5'(16 + int'(f3));
      else ok = 1'b0;
    end else if (op == 7'h13) begin
      e.it = 1'b1;
      if (f3 == 3'd1 || f3 == 3'd5) begin
        e.imm = 32'(ins[24:20]);
        if (f3 == 3'd1) begin e.alu = 5'd2; ok = (f7 == 7'h00); end
        else if (f7 == 7'h00) e.alu = 5'd6;
        else if (f7 == 7'h20) e.alu = 5'd7;
        else ok = 1'b0;
      end else begin
        e.imm = {{20{ins[31]}}, ins[31:20]};
        e.alu = 5'(F3Alu[f3]);
      end
    end else if (op == 7'h03) begin
      e.ld = 1'b1; e.imm = {{20{ins[31]}}, ins[31:20]};
      e.msz = f3[1:0]; e.muns = f3[2];
      ok = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    end else if (op == 7'h23) begin
      e.st = 1'b1; e.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      e.msz = f3[1:0]; ok = (f3 <= 3'd2);
    end else if (op == 7'h63) begin
      e.br = 1'b1;
      e.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      ok = !(f3 == 3'd2 || f3 == 3'd3);
    end else if (op == 7'h37) begin
      e.up = 1'b1; e.imm = ins & 32'hFFFF_F000; e.alu = 5'd10;
    end else if (op == 7'h17) begin
      e.ap = 1'b1; e.imm = ins & 32'hFFFF_F000;
    end else if (op == 7'h6F) begin
      e.jl = 1'b1;
      e.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    end else if (op == 7'h67) begin
      e.jr = 1'b1; e.imm = {{20{ins[31]}}, ins[31:20]}; ok = (f3 == 3'd0);
    end else begin
      ok = 1'b0;
    end
    if (!ok) begin
      e     = '0;
      e.pc  = pc;
      e.rd  = ins[11:7];
      e.rs1 = ins[19:15];
      e.rs2 = ins[24:20];
      e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [6:0]  opcs [9];
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
    w = $urandom;
    case ($urandom_range(0, 11))
      0, 1: begin
        w[6:0] = 7'h33;
        case ($urandom_range(0, 3))
          0: w[31:25] = 7'h00;
          1: w[31:25] = 7'h20;
          2: w[31:25] = 7'h01;
          default: ;
        endcase
      end
      2: begin
        w[6:0] = 7'h13;
        if ($urandom_range(0, 2) == 0) w[31:25] = 7'h20;
        else if ($urandom_range(0, 1) == 0) w[31:25] = 7'h00;
      end
      3, 4, 5, 6: w[6:0] = opcs[$urandom_range(2, 8)];
      7: begin
        w[6:0] = 7'h67;
        if ($urandom_range(0, 2) != 0) w[14:12] = 3'd0;
      end
      8: begin
        w[6:0] = 7'h13;
        w[1:0] = 2'($urandom_range(0, 2));
      end
      default: ;
    endcase
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: check occupancy/counter, drive inputs, update the model, advance
  task automatic step(input logic v, input logic [31:0] ins, input logic rdy,
                      input logic fl, input logic rst);
    exp_t e;
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("illegal_count", 32'(illegal_count), (cnt > 65535) ? 65535 : cnt);
    chk("sat_count", 32'(s_illegal_count), (cnt > 7) ? 7 : cnt);
    rst_n     = !rst;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc_ctr;
    out_ready = rdy;
    flush     = fl;
    if (rst) begin
      q.delete();
      cnt = 0;
    end else if (fl) begin
      q.delete();
    end else if (v && in_ready) begin
      e = ref_decode(ins, pc_ctr);
      q.push_back(e);
      if (e.ill) cnt++;
    end
    pc_ctr += 32'd4;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every transfer to execute is compared with the oldest expected entry
  always @(negedge clk) begin
    exp_t a, e;
    if (rst_n && !flush && out_valid && out_ready) begin
      a = '{out_pc, out_rd, out_rs1, out_rs2, out_imm, out_store, out_load, out_i_type,
            out_r_type, out_branch, out_upper, out_add_u_pc, out_jmp_link, out_jmp_linkr,
            out_mem_size, out_mem_unsigned, out_alu_ctrl, out_illegal};
      n_checks++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got pc %h expected no entry", out_pc);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          n_err++;
          $display("FAIL entry pc=%h: got %h expected %h", e.pc, a, e);
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_imm", out_imm, 32'd0);
    chk("reset out_alu_ctrl", 32'(out_alu_ctrl), 32'd0);
    chk("reset flags", 32'({out_store, out_load, out_i_type, out_r_type, out_branch,
        out_upper, out_add_u_pc, out_jmp_link, out_jmp_linkr, out_illegal}), 32'd0);
    chk("reset illegal_count", 32'(illegal_count), 32'd0);

    // ADD x3,x1,x2
    step(1'b1, 32'h002081B3, 1'b1, 1'b0, 1'b0);
    chk("add valid", 32'(out_valid), 32'd1);
    chk("add r_type", 32'(out_r_type), 32'd1);
    chk("add alu", 32'(out_alu_ctrl), 32'd0);
    chk("add regs", 32'({out_rd, out_rs1, out_rs2}), 32'({5'd3, 5'd1, 5'd2}));
    // SRAI x5,x5,4
    step(1'b1, 32'h4042D293, 1'b1, 1'b0, 1'b0);
    chk("srai i_type", 32'(out_i_type), 32'd1);
    chk("srai alu", 32'(out_alu_ctrl), 32'd7);
    chk("srai imm", out_imm, 32'd4);
    // ADDI x1,x0,-1
    step(1'b1, 32'hFFF00093, 1'b1, 1'b0, 1'b0);
    chk("addi alu", 32'(out_alu_ctrl), 32'd0);
    chk("addi imm", out_imm, 32'hFFFF_FFFF);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Back-pressure: LW, SB accepted, LUI held until the stage drains
    step(1'b1, 32'h0000A103, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00208023, 1'b0, 1'b0, 1'b0);
    chk("full in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 32'h123450B7, 1'b0, 1'b0, 1'b0);
    chk("held main pc", out_pc, pc_ctr - 32'd12);
    step(1'b1, 32'h123450B7, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h123450B7, 1'b1, 1'b0, 1'b0);
    chk("lui upper", 32'(out_upper), 32'd1);
    chk("lui alu", 32'(out_alu_ctrl), 32'd10);
    chk("lui imm", out_imm, 32'h1234_5000);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush from FULL with an illegal instruction on offer
    step(1'b1, 32'h0000A103, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00208023, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0);
    chk("flush out_valid", 32'(out_valid), 32'd0);
    chk("flush in_ready", 32'(in_ready), 32'd1);
    chk("flush count", 32'(illegal_count), 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Illegal words
    step(1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0);
    chk("ill0 illegal", 32'(out_illegal), 32'd1);
    chk("ill0 flags", 32'({out_store, out_load, out_i_type, out_r_type, out_branch,
        out_upper, out_add_u_pc, out_jmp_link, out_jmp_linkr, out_alu_ctrl}), 32'd0);
    step(1'b1, 32'h0000707F, 1'b1, 1'b0, 1'b0);
    chk("ill1 illegal", 32'(out_illegal), 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("two illegals", 32'(illegal_count), 32'd2);

    // MUL x1,x2,x3
    step(1'b1, 32'h023100B3, 1'b1, 1'b0, 1'b0);
    chk("mul illegal", 32'(out_illegal), MExt ? 32'd0 : 32'd1);
    chk("mul alu", 32'(out_alu_ctrl), MExt ? 32'd16 : 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic
    repeat (3000) begin
      step(1'($urandom_range(0, 3) != 0), gen_instr(), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 299) == 0));
    end
    repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("drained", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
